// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_det_pkg;

  // Pattern and match mode loaded at reset; MSB of the pattern is the first bit received.
  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam logic       DEF_OVERLAP = 1'b1;

  // Detector phase: history not yet full versus able to report matches.
  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } phase_e;

  // Width needed to hold a fill count of 0..pat_len inclusive.
  function automatic int FILL_W(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment on the same edge yields 1.
// Latency: q reflects clr/inc one cycle after the edge that samples them.
// Backpressure: none; inc is accepted every cycle and is dropped silently once saturated.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  // Clear takes priority but still counts a coincident increment; otherwise count up and stick at MAX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= W'(inc);
    end else if (inc && (q != MAX)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_det_prog.sv
// Runtime-programmable PAT_LEN-bit serial pattern detector with overlap mode and match counter.
// Latency: match pulses one cycle after the edge that samples the final pattern bit.
// Backpressure: none; din is sampled whenever din_valid is high and gaps simply hold the history.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0] DEF_PATTERN = PAT_LEN'(seq_det_pkg::DEF_PATTERN),
  parameter logic               DEF_OVERLAP = seq_det_pkg::DEF_OVERLAP,
  parameter int                 CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          din_valid,
  input  logic                          din,
  input  logic                          cfg_load,
  input  logic [PAT_LEN-1:0]            cfg_pattern,
  input  logic                          cfg_overlap,
  input  logic                          clr_cnt,
  output logic                          match,
  output logic [CNT_W-1:0]              match_cnt,
  output logic [FILL_W(PAT_LEN)-1:0]    fill
);

  localparam int            FW   = FILL_W(PAT_LEN);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] pattern_q, pattern_d;
  logic               overlap_q, overlap_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               match_q, match_d;

  logic [PAT_LEN-1:0] hist_n;
  logic [FW-1:0]      fill_inc;
  phase_e             phase_n;
  logic               hit;

  // Detector state register; reset drops any partial history immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_q <= DEF_PATTERN;
      overlap_q <= DEF_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
    end
  end

  // Next-state: cfg_load restarts detection, a valid bit shifts in, idle cycles hold.
  always_comb begin
    hist_n    = {hist_q[PAT_LEN-2:0], din};
    fill_inc  = (fill_q == FULL) ? FULL : (fill_q + FW'(1));
    // Phase after this sample; the fill gate keeps the zeroed history from matching an all-zero pattern.
    phase_n   = (fill_inc == FULL) ? ARMED : FILLING;
    hit       = din_valid && !cfg_load && (phase_n == ARMED) && (hist_n == pattern_q);

    pattern_d = pattern_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = hit;

    if (cfg_load) begin
      pattern_d = cfg_pattern;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (din_valid) begin
      hist_d = hist_n;
      // Non-overlapping mode discards the matched bits so the next match needs a full fresh pattern.
      fill_d = (hit && !overlap_q) ? '0 : fill_inc;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (hit),
    .q   (match_cnt)
  );

  assign match = match_q;
  assign fill  = fill_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Self-checking bench for seq_det_prog: directed scenarios plus randomized traffic against a queue-based model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_seq_det_prog;
  import seq_det_pkg::*;

  localparam int PL  = 4;
  localparam int CW  = 2;
  localparam int FWT = FILL_W(PL);

  logic           clk;
  logic           rst;
  logic           din_valid;
  logic           din;
  logic           cfg_load;
  logic [PL-1:0]  cfg_pattern;
  logic           cfg_overlap;
  logic           clr_cnt;
  logic           match;
  logic [CW-1:0]  match_cnt;
  logic [FWT-1:0] fill;

  int tests;
  int fails;

  seq_det_prog #(
    .PAT_LEN     (PL),
    .DEF_PATTERN (4'b1011),
    .DEF_OVERLAP (1'b1),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din_valid   (din_valid),
    .din         (din),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .clr_cnt     (clr_cnt),
    .match       (match),
    .match_cnt   (match_cnt),
    .fill        (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: the bit stream since the last restart and how many of those bits are still usable.
  logic [PL-1:0] m_pat;
  logic          m_ov;
  bit            m_bits[$];
  int            m_avail;
  int            m_cnt;
  int            m_match;
  bit            chk_en;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pat   = 4'b1011;
    m_ov    = 1'b1;
    m_bits.delete();
    m_avail = 0;
    m_cnt   = 0;
    m_match = 0;
  endtask

  task automatic model_step(input bit v, input bit d, input bit cl, input logic [PL-1:0] cp,
                            input bit co, input bit cc);
    int  w;
    bit  hit;
    hit = 1'b0;
    if (cl) begin
      m_pat = cp;
      m_ov  = co;
      m_bits.delete();
      m_avail = 0;
    end else if (v) begin
      m_bits.push_back(d);
      if (m_bits.size() > 16) void'(m_bits.pop_front());
      m_avail++;
      if (m_avail >= PL) begin
        w = 0;
        for (int i = 0; i < PL; i++) w = (w << 1) | int'(m_bits[m_bits.size() - PL + i]);
        hit = (w == int'(m_pat));
      end
      if (hit && !m_ov) m_avail = 0;
    end
    if (cc)                              m_cnt = hit ? 1 : 0;
    else if (hit && m_cnt < (1 << CW) - 1) m_cnt++;
    m_match = hit ? 1 : 0;
  endtask

  // Drive one clock's worth of inputs, advance the model on that edge, then step off the edge.
  task automatic apply(input bit v, input bit d, input bit cl, input logic [PL-1:0] cp,
                       input bit co, input bit cc);
    din_valid   = v;
    din         = d;
    cfg_load    = cl;
    cfg_pattern = cp;
    cfg_overlap = co;
    clr_cnt     = cc;
    @(posedge clk);
    model_step(v, d, cl, cp, co, cc);
    #1;
  endtask

  task automatic bitin(input bit d, input bit cc);
    apply(1'b1, d, 1'b0, 4'b0000, 1'b0, cc);
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [PL-1:0] p, input bit ov, input bit cc);
    apply(1'b0, 1'b0, 1'b1, p, ov, cc);
  endtask

  // Continuous comparison against the model, half a cycle away from the sampling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_match", int'(match), m_match);
      chk("cyc_cnt", int'(match_cnt), m_cnt);
      chk("cyc_fill", int'(fill), (m_avail < PL) ? m_avail : PL);
    end
  end

  initial begin
    logic [6:0] s1;
    logic [7:0] m5;
    int         c5[8];

    tests = 0;
    fails = 0;
    chk_en = 1'b0;
    din_valid = 1'b0; din = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_overlap = 1'b0; clr_cnt = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_match", int'(match), 0);
    chk("rst_cnt", int'(match_cnt), 0);
    chk("rst_fill", int'(fill), 0);
    rst = 1'b1;
    #1;
    chk_en = 1'b1;

    // Defaults 1011 overlapping: stream 1011011 matches after bits 4 and 7.
    s1 = 7'b1011011;
    for (int i = 0; i < 7; i++) begin
      bitin(s1[6-i], 1'b0);
      chk($sformatf("t1_match_b%0d", i + 1), int'(match), (i == 3 || i == 6) ? 1 : 0);
    end
    chk("t1_cnt", int'(match_cnt), 2);

    // Non-overlapping 1011: same stream, single match, three leftover bits.
    load(4'b1011, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      bitin(s1[6-i], 1'b0);
      chk($sformatf("t2_match_b%0d", i + 1), int'(match), (i == 3) ? 1 : 0);
    end
    chk("t2_cnt", int'(match_cnt), 1);
    chk("t2_fill", int'(fill), 3);

    // Gaps in din_valid between bits do not break the sequence; pulse is one cycle wide.
    load(4'b1011, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bitin((i == 1) ? 1'b0 : 1'b1, 1'b0);
      chk($sformatf("t3_match_b%0d", i + 1), int'(match), (i == 3) ? 1 : 0);
      for (int g = 0; g < 3; g++) begin
        idle();
        chk($sformatf("t3_gap_b%0d_%0d", i + 1, g), int'(match), 0);
      end
    end
    chk("t3_cnt", int'(match_cnt), 1);

    // Partial prefix 101 is discarded by cfg_load, whose own din is ignored.
    bitin(1'b1, 1'b0); bitin(1'b0, 1'b0); bitin(1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0);
    chk("t4_load_match", int'(match), 0);
    chk("t4_load_fill", int'(fill), 0);
    for (int i = 0; i < 4; i++) begin
      bitin((i == 1 || i == 2) ? 1'b1 : 1'b0, 1'b0);
      chk($sformatf("t4_match_b%0d", i + 1), int'(match), (i == 3) ? 1 : 0);
    end
    chk("t4_fill", int'(fill), 4);
    chk("t4_cnt", int'(match_cnt), 2);

    // 1111 overlapping on eight 1s: counter saturates at 3, clear with a coincident hit gives 1.
    load(4'b1111, 1'b1, 1'b1);
    m5 = 8'b0001_1111;
    c5 = '{0, 0, 0, 1, 2, 3, 3, 1};
    for (int i = 0; i < 8; i++) begin
      bitin(1'b1, (i == 7) ? 1'b1 : 1'b0);
      chk($sformatf("t5_match_b%0d", i + 1), int'(match), int'(m5[7-i]));
      chk($sformatf("t5_cnt_b%0d", i + 1), int'(match_cnt), c5[i]);
    end

    // Asynchronous reset between edges drops history and counter at once.
    load(4'b1011, 1'b1, 1'b0);
    bitin(1'b1, 1'b0); bitin(1'b0, 1'b0); bitin(1'b1, 1'b0);
    chk("t6_pre_fill", int'(fill), 3);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_match", int'(match), 0);
    chk("t6_rst_cnt", int'(match_cnt), 0);
    chk("t6_rst_fill", int'(fill), 0);
    rst = 1'b1;
    bitin(1'b1, 1'b0);
    chk("t6_post_match", int'(match), 0);
    chk("t6_post_fill", int'(fill), 1);

    // Randomized traffic, including all-zero patterns and mode changes, checked every cycle.
    for (int n = 0; n < 3000; n++) begin
      logic [PL-1:0] rp;
      bit rv, rd, rl, ro, rc;
      rv = ($urandom_range(0, 9) < 7);
      rd = $urandom_range(0, 1) == 1;
      rl = ($urandom_range(0, 99) == 0);
      ro = $urandom_range(0, 1) == 1;
      rc = ($urandom_range(0, 49) == 0);
      rp = ($urandom_range(0, 3) == 0) ? 4'b0000 : PL'($urandom_range(0, 15));
      apply(rv, rd, rl, rp, ro, rc);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
